seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//   Receive-side monitor for the multiplexed 7-segment display bus (seg/an/dp1) that the decade-counter top drives.
//   Samples the scanned anodes and segments, decodes each lit digit back to BCD, and publishes the full
//   NUM_DIGITS value once per complete scan frame. Used in benches and on-chip self-check to read the display.
// PARAMETERS
//   NUM_DIGITS     2   digits decoded: anode indices 0..NUM_DIGITS-1 (1..8)
//   AN_WIDTH       8   width of anode bus
//   SETTLE_CYCLES  4   consecutive identical registered cycles of {an,seg,dp1} required before a capture (>=1)
// PORTS
//   clk        in   1               system clock
//   rst        in   1               asynchronous, active-high reset
//   seg        in   7               segment cathodes, active-low; seg[0]=a .. seg[6]=g
//   an         in   AN_WIDTH        anodes, active-low, one digit enabled per dwell
//   dp1        in   1               decimal point, active-low
//   value      out  4*NUM_DIGITS    published BCD; digit i at value[4i+3:4i]
//   dp_out     out  NUM_DIGITS      published dp state per digit, 1 = lit
//   value_vld  out  1               1-cycle pulse: new frame published
//   value_chg  out  1               1-cycle pulse with value_vld when value or dp_out differs from previous publish
//   seg_err    out  1               1-cycle pulse: captured pattern not a digit 0-9
//   scan_err   out  1               1-cycle pulse: more than one anode low in a settled sample
// BEHAVIOUR
//   Reset: all outputs 0, capture mask 0, shadow regs 0, settle counter 0, FSM = ARMED. Async assert, sync release.
//   Input stage: seg, an, dp1 registered once (an_r, seg_r, dp_r).
//   Settle counter: any change of {an_r,seg_r,dp_r} vs previous cycle -> cnt=0, FSM=ARMED; else cnt saturates at SETTLE_CYCLES-1.
//   FSM: ARMED -> (cnt==SETTLE_CYCLES-1 and unchanged) evaluate sample, go DONE; DONE -> ARMED only on input change.
//     So at most one evaluation per anode dwell, however long the dwell.
//   Evaluation of settled sample:
//     an_r all ones (blank)                  -> no capture, no error.
//     >1 bit of an_r low                     -> scan_err pulse, no capture.
//     one bit low, index >= NUM_DIGITS       -> ignored silently.
//     one bit low, index i < NUM_DIGITS      -> shadow digit i <= decode(seg_r), shadow dp i <= ~dp_r, mask[i] <= 1.
//   Decode (active-high gfedcba = ~seg_r): 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8 6F=9.
//     Any other pattern -> nibble 4'hF and seg_err pulse same cycle as capture; still sets mask bit.
//   Re-capture of an already-masked digit before frame complete overwrites it (latest wins).
//   Frame publish: cycle after mask becomes all-ones: value<=shadow, dp_out<=shadow dp, value_vld=1, mask<=0.
//     value_chg=1 in the same cycle iff new {value,dp_out} != old {value,dp_out}. First publish after reset
//     compares against 0, so value 00 with no dp gives no value_chg.
//   Latency: pins constant from cycle T -> capture at end of cycle T+SETTLE_CYCLES; if that completes the
//     frame, value_vld is high in cycle T+SETTLE_CYCLES+1.
//   Capture and publish overlap: a capture in the publish cycle lands in the freshly cleared mask (not lost).
//   Reset mid-frame: partial mask and shadow discarded; value returns to 0; no value_vld until a new full frame.
//   value/dp_out hold between publishes; pulses never wider than one cycle.
// TESTING
//   1 an=FE seg=0110000 ("3") 10 cyc, then an=FD seg=1000000 ("0") 10 cyc -> value=8'h03, value_vld+value_chg 1 pulse each.
//   2 repeat identical frame -> value_vld pulse, value_chg stays 0, value=8'h03.
//   3 an=FE seg=1111110 (only a lit), then an=FD "7" (1111000) -> seg_err pulse on digit0; value=8'h7F.
//   4 an=FC seg=0010000 held 10 cyc -> scan_err single pulse, mask unchanged, no value_vld.
//   5 SETTLE_CYCLES=4: an=FE "9" held 2 cyc then "1" (1111001) held 10 cyc, then an=FD "0" -> value=8'h01.
//   6 capture digit0, assert rst 3 cyc mid-dwell, then only an=FD "5" (0010010) -> value=0, no value_vld; add an=FE "2" -> value=8'h52.
//   7 dp1=0 while an=FD "4" (0011001), dp1=1 on digit0 "8" (0000000) -> dp_out=2'b10, value=8'h48.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a multiplexed 7-segment bus. It decodes each settled anode dwell back to BCD
// and publishes the full NUM_DIGITS value once every digit of a frame has been captured.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 2,
  parameter int AN_WIDTH      = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [AN_WIDTH-1:0]     an,
  input  logic                    dp1,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic                    value_vld,
  output logic                    value_chg,
  output logic                    seg_err,
  output logic                    scan_err
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [0:0] ARMED = 1'b0;
  localparam logic [0:0] DONE  = 1'b1;

  logic [AN_WIDTH-1:0]     an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [0:0]              state_q, state_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_out_q, dp_out_d;
  logic                    vld_q, vld_d;
  logic                    chg_q, chg_d;
  logic                    seg_err_q, seg_err_d;
  logic                    scan_err_q, scan_err_d;

  logic                    changed;
  logic                    eval;
  logic [AN_WIDTH-1:0]     an_lit;
  logic                    an_blank;
  logic                    an_multi;
  logic [NUM_DIGITS-1:0]   cap;
  logic [NUM_DIGITS-1:0]   merged;
  logic                    full;
  logic [3:0]              digit;
  logic                    digit_bad;

  function automatic logic [4:0] decode(input logic [6:0] gfedcba);
    case (gfedcba)
      7'h3F:   decode = {1'b0, 4'd0};
      7'h06:   decode = {1'b0, 4'd1};
      7'h5B:   decode = {1'b0, 4'd2};
      7'h4F:   decode = {1'b0, 4'd3};
      7'h66:   decode = {1'b0, 4'd4};
      7'h6D:   decode = {1'b0, 4'd5};
      7'h7D:   decode = {1'b0, 4'd6};
      7'h07:   decode = {1'b0, 4'd7};
      7'h7F:   decode = {1'b0, 4'd8};
      7'h6F:   decode = {1'b0, 4'd9};
      default: decode = {1'b1, 4'hF};
    endcase
  endfunction

  // The change test looks at the pins against the registered copy, so the counter restarts on the
  // same edge that loads a new sample and a capture lands SETTLE_CYCLES cycles after the pins settle.
  always_comb begin
    changed = ({an, seg, dp1} != {an_q, seg_q, dp_q});
    cnt_d   = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
    eval    = (state_q == ARMED) && (cnt_q == CNT_MAX);
    state_d = changed ? ARMED : (eval ? DONE : state_q);
  end

  always_comb begin
    an_lit   = ~an_q;
    an_blank = (an_lit == '0);
    an_multi = ((an_lit & (an_lit - AN_WIDTH'(1))) != '0);
    cap      = (eval && !an_blank && !an_multi) ? an_lit[NUM_DIGITS-1:0] : '0;
    {digit_bad, digit} = decode(~seg_q);
    scan_err_d = eval && an_multi;
    seg_err_d  = (cap != '0) && digit_bad;
  end

  // Publishing happens on the edge whose capture completes the mask, so the mask is cleared
  // in the same step and a following capture always starts a fresh frame.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap[i]) begin
        shadow_val_d[4*i +: 4] = digit;
        shadow_dp_d[i]         = ~dp_q;
      end
    end
    merged   = mask_q | cap;
    full     = &merged;
    mask_d   = full ? '0 : merged;
    vld_d    = full;
    value_d  = full ? shadow_val_d : value_q;
    dp_out_d = full ? shadow_dp_d : dp_out_q;
    chg_d    = full && ({shadow_val_d, shadow_dp_d} != {value_q, dp_out_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q         <= '1;
      seg_q        <= '1;
      dp_q         <= 1'b1;
      cnt_q        <= '0;
      state_q      <= ARMED;
      mask_q       <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      value_q      <= '0;
      dp_out_q     <= '0;
      vld_q        <= 1'b0;
      chg_q        <= 1'b0;
      seg_err_q    <= 1'b0;
      scan_err_q   <= 1'b0;
    end else begin
      an_q         <= an;
      seg_q        <= seg;
      dp_q         <= dp1;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      mask_q       <= mask_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      value_q      <= value_d;
      dp_out_q     <= dp_out_d;
      vld_q        <= vld_d;
      chg_q        <= chg_d;
      seg_err_q    <= seg_err_d;
      scan_err_q   <= scan_err_d;
    end
  end

  assign value     = value_q;
  assign dp_out    = dp_out_q;
  assign value_vld = vld_q;
  assign value_chg = chg_q;
  assign seg_err   = seg_err_q;
  assign scan_err  = scan_err_q;

endmodule
